usi_dma_arb: RTL

USI_DMA_ARB -- requirements
Module: usi_dma_arb

---
 rtl/usi_dma_arb_pkg.sv | 16 +
 rtl/usi_dma_rr_pick.sv | 34 +++
 rtl/usi_dma_arb.sv | 138 +++++++++++++
 3 files changed

// File: rtl/usi_dma_arb_pkg.sv
// Shared definitions for the USI DMA arbiter: FSM encoding, source index width, timeout default.
// Latency: none (definitions only).
// Backpressure: not applicable.
package usi_dma_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int SRC_W           = 3;
    localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/usi_dma_rr_pick.sv
// Round-robin picker: first set bit of elig at or after ptr, wrapping modulo NUM_SRC.
// Latency: purely combinational.
// Backpressure: none; pick_vld is low when elig is empty.
module usi_dma_rr_pick
    import usi_dma_arb_pkg::*;
#(
    parameter int NUM_SRC = 6
) (
    input  logic [NUM_SRC-1:0] elig,
    input  logic [SRC_W-1:0]   ptr,
    output logic               pick_vld,
    output logic [SRC_W-1:0]   pick_idx
);

    // Scan offsets from farthest to nearest so the nearest eligible source wins.
    always_comb begin
        int                 idx;
        logic [SRC_W-1:0]   idx_s;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        idx_s    = '0;
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            idx_s = SRC_W'(idx);
            if (elig[idx_s]) begin
                pick_vld = 1'b1;
                pick_idx = idx_s;
            end
        end
    end

endmodule

// File: rtl/usi_dma_arb.sv
// Round-robin arbiter granting one DMA handshake channel among USI RX/TX sources; timeout under USI_DMA_ARB_TMO_EN.
// Latency: dma_req one cycle after an eligible request in IDLE; minimum four cycles per transfer.
// Backpressure: a grant holds until dma_ack (or timeout); the granted request must drop before re-arbitration.
module usi_dma_arb
    import usi_dma_arb_pkg::*;
#(
    parameter int NUM_USI     = 3,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_USI-1:0]     usi_req_rx,
    input  logic [NUM_USI-1:0]     usi_req_tx,
    input  logic [2*NUM_USI-1:0]   src_en,
    output logic [NUM_USI-1:0]     usi_ack_rx,
    output logic [NUM_USI-1:0]     usi_ack_tx,
    output logic                   dma_req,
    output logic [SRC_W-1:0]       dma_src,
    input  logic                   dma_ack,
    output logic                   arb_busy,
    output logic                   arb_tmo_intr
);

    localparam int               NUM_SRC  = 2 * NUM_USI;
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

    arb_state_t         state, state_nxt;
    logic [SRC_W-1:0]   ptr, ptr_nxt, src_nxt, pick_idx;
    logic [NUM_SRC-1:0] req_vec, elig, ack_vec, ack_nxt;
    logic               req_nxt, busy_nxt, pick_vld;

    // Sources interleave as RX of USI i at 2*i, TX at 2*i+1.
    always_comb begin
        req_vec    = '0;
        usi_ack_rx = '0;
        usi_ack_tx = '0;
        for (int i = 0; i < NUM_USI; i++) begin
            req_vec[2*i]   = usi_req_rx[i];
            req_vec[2*i+1] = usi_req_tx[i];
            usi_ack_rx[i]  = ack_vec[2*i];
            usi_ack_tx[i]  = ack_vec[2*i+1];
        end
    end

    assign elig = req_vec & src_en;

    usi_dma_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .elig     (elig),
        .ptr      (ptr),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx)
    );

`ifdef USI_DMA_ARB_TMO_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_cnt, tmo_cnt_nxt;
    logic        tmo_q, tmo_nxt;

    assign arb_tmo_intr = tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_cnt <= tmo_cnt_nxt;
            tmo_q   <= tmo_nxt;
        end
    end
`else
    assign arb_tmo_intr = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        req_nxt   = dma_req;
        src_nxt   = dma_src;
        ack_nxt   = '0;
`ifdef USI_DMA_ARB_TMO_EN
        tmo_cnt_nxt = tmo_cnt;
        tmo_nxt     = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ST_GRANT;
                    req_nxt   = 1'b1;
                    src_nxt   = pick_idx;
                    ptr_nxt   = (pick_idx == LAST_SRC) ? '0 : pick_idx + 1'b1;
`ifdef USI_DMA_ARB_TMO_EN
                    tmo_cnt_nxt = '0;
`endif
                end
            end
            ST_GRANT: begin
                // dma_ack is checked first so it beats a coincident timeout.
                if (dma_ack) begin
                    state_nxt        = ST_ACK;
                    req_nxt          = 1'b0;
                    ack_nxt[dma_src] = 1'b1;
                end
`ifdef USI_DMA_ARB_TMO_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = ST_RELEASE;
                    req_nxt   = 1'b0;
                    tmo_nxt   = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
`endif
            end
            ST_ACK:     state_nxt = ST_RELEASE;
            // Hold off re-arbitration until the served source drops its level request.
            ST_RELEASE: if (!req_vec[dma_src]) state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            dma_req  <= 1'b0;
            dma_src  <= '0;
            ack_vec  <= '0;
            arb_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            dma_req  <= req_nxt;
            dma_src  <= src_nxt;
            ack_vec  <= ack_nxt;
            arb_busy <= busy_nxt;
        end
    end

endmodule
